// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline register sequencer.
package pipeline_ctrl_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } ctrl_state_e;

   localparam int REG_W_DEF     = 5;
   localparam int MC_CYCLES_DEF = 4;
   localparam int CNT_W_DEF     = 32;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the datapath and register enables/flushes back to it.
interface pipeline_ctrl_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
);
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [REG_W-1:0] ex_rd;
   logic             ex_mem_read;
   logic             ex_br_taken;
   logic             ex_mc_start;
   logic             mem_stall;

   logic             pc_we;
   logic             ifid_we;
   logic             idex_we;
   logic             exmem_we;
   logic             memwb_we;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_flush;
   logic             mc_busy;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             ex_br_taken, ex_mc_start, mem_stall,
      input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
             ifid_flush, idex_flush, exmem_flush, mc_busy, stall_cycles
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             ex_br_taken, ex_mc_start, mem_stall,
      output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
             ifid_flush, idex_flush, exmem_flush, mc_busy, stall_cycles
   );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use compare between the load in EX and the sources read in ID.
module hazard_detect #(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_mem_read,
   output logic             lu_stall
);
   logic hit_rs1;
   logic hit_rs2;

   assign hit_rs1  = id_use_rs1 && (id_rs1 == ex_rd);
   assign hit_rs2  = id_use_rs2 && (id_rs2 == ex_rd);
   // x0 is hardwired zero, so a load targeting it never creates a dependency
   assign lu_stall = ex_mem_read && (ex_rd != '0) && (hit_rs1 || hit_rs2);
endmodule

// File: rtl/pipeline_ctrl.sv
// Write-enable / flush sequencer for the five pipeline registers, with a
// saturating stall-cycle counter.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   RUN     | normal issue; branch, multicycle and load-use hazards handled
//   MC_WAIT | multicycle op held in EX; bubbles into EX/MEM until mc_cnt==0
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_W     = REG_W_DEF,
   parameter int MC_CYCLES = MC_CYCLES_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   pipeline_ctrl_if.slave bus
);
   localparam int            MC_W    = $clog2(MC_CYCLES + 1);
   localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_CYCLES - 1);

   ctrl_state_e      state, state_nxt;
   logic [MC_W-1:0]  mc_cnt, mc_cnt_nxt;
   logic [CNT_W-1:0] stall_cnt;
   logic [4:0]       we;      // {pc, ifid, idex, exmem, memwb}
   logic [2:0]       flush;   // {ifid, idex, exmem}
   logic             lu_stall;

   hazard_detect #(.REG_W(REG_W)) u_hazard (
      .id_rs1      (bus.id_rs1),
      .id_rs2      (bus.id_rs2),
      .id_use_rs1  (bus.id_use_rs1),
      .id_use_rs2  (bus.id_use_rs2),
      .ex_rd       (bus.ex_rd),
      .ex_mem_read (bus.ex_mem_read),
      .lu_stall    (lu_stall)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= RUN;
         mc_cnt <= '0;
      end else begin
         state  <= state_nxt;
         mc_cnt <= mc_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      mc_cnt_nxt = mc_cnt;
      we         = 5'b11111;
      flush      = 3'b000;
      if (bus.mem_stall) begin
         we = 5'b00000;
         if (state == MC_WAIT && mc_cnt != '0) mc_cnt_nxt = mc_cnt - MC_W'(1);
      end else if (state == MC_WAIT) begin
         if (mc_cnt != '0) begin
            we         = 5'b00011;
            flush      = 3'b001;
            mc_cnt_nxt = mc_cnt - MC_W'(1);
         end else begin
            state_nxt = RUN;
         end
      end else if (bus.ex_br_taken) begin
         flush = 3'b110;
      end else if (bus.ex_mc_start) begin
         we         = 5'b00011;
         flush      = 3'b001;
         mc_cnt_nxt = MC_LOAD;
         state_nxt  = MC_WAIT;
      end else if (lu_stall) begin
         we    = 5'b00111;
         flush = 3'b010;
      end
      // Hold every register while reset is asserted
      if (!rst) begin
         we    = 5'b00000;
         flush = 3'b000;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (!we[4] && stall_cnt != '1) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we} = we;
   assign {bus.ifid_flush, bus.idex_flush, bus.exmem_flush}                 = flush;
   assign bus.mc_busy      = (state == MC_WAIT);
   assign bus.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed hazard cases, counter
// saturation (narrow counter) and randomized traffic against a cycle model.
module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   localparam int REG_W     = 5;
   localparam int MC_CYCLES = 4;
   localparam int CNT_W     = 6;
   localparam longint SAT   = (64'd1 << CNT_W) - 1;

   typedef struct packed {
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic             u1;
      logic             u2;
      logic [REG_W-1:0] rd;
      logic             mr;
      logic             br;
      logic             mc;
      logic             ms;
   } stim_t;

   typedef struct packed {
      logic [4:0]       we;
      logic [2:0]       fl;
      logic             busy;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   exp_t  exp_q[$];
   string name_q[$];

   int     m_left   = 0;
   longint m_stalls = 0;

   pipeline_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

   pipeline_ctrl #(.REG_W(REG_W), .MC_CYCLES(MC_CYCLES), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) assert (!(bus.ex_br_taken && bus.ex_mc_start))
         else $error("illegal ex_br_taken together with ex_mc_start");
   end

   function automatic stim_t mk(input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                                input logic u1, input logic u2, input logic [REG_W-1:0] rd,
                                input logic mr, input logic br, input logic mc, input logic ms);
      stim_t s;
      s = '{rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, mr: mr, br: br, mc: mc, ms: ms};
      return s;
   endfunction

   // m_left: cycles the multicycle op still has to spend held in EX,
   // the final one being the release cycle.
   task automatic model(input stim_t s, output exp_t e);
      bit lu;
      lu = s.mr && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      e.we   = 5'b11111;
      e.fl   = 3'b000;
      e.busy = (m_left != 0);
      e.cnt  = m_stalls[CNT_W-1:0];
      if (s.ms) begin
         e.we = 5'b00000;
         if (m_left > 1) m_left = m_left - 1;
      end else if (m_left > 1) begin
         e.we   = 5'b00011;
         e.fl   = 3'b001;
         m_left = m_left - 1;
      end else if (m_left == 1) begin
         m_left = 0;
      end else if (s.br) begin
         e.fl = 3'b110;
      end else if (s.mc) begin
         e.we   = 5'b00011;
         e.fl   = 3'b001;
         m_left = MC_CYCLES;
      end else if (lu) begin
         e.we = 5'b00111;
         e.fl = 3'b010;
      end
      if (!e.we[4] && m_stalls < SAT) m_stalls = m_stalls + 1;
   endtask

   task automatic drive(input stim_t s, input string nm);
      exp_t e;
      @(negedge clk);
      rst             = 1'b1;
      bus.id_rs1      = s.rs1;
      bus.id_rs2      = s.rs2;
      bus.id_use_rs1  = s.u1;
      bus.id_use_rs2  = s.u2;
      bus.ex_rd       = s.rd;
      bus.ex_mem_read = s.mr;
      bus.ex_br_taken = s.br;
      bus.ex_mc_start = s.mc;
      bus.mem_stall   = s.ms;
      model(s, e);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic reset_cycles(input int n, input string nm);
      repeat (n) begin
         @(negedge clk);
         rst      = 1'b0;
         m_left   = 0;
         m_stalls = 0;
         exp_q.push_back('0);
         name_q.push_back(nm);
      end
   endtask

   initial begin : monitor
      exp_t       e;
      string      nm;
      logic [8:0] act;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we,
                   bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.mc_busy};
            checks++;
            if (act !== {e.we, e.fl, e.busy}) begin
               errors++;
               $display("FAIL %s ctrl got=%b want=%b (we[5] fl[3] busy)", nm, act,
                        {e.we, e.fl, e.busy});
            end
            checks++;
            if (bus.stall_cycles !== e.cnt) begin
               errors++;
               $display("FAIL %s stall_cycles got=%0d want=%0d", nm, bus.stall_cycles, e.cnt);
            end
         end
      end
   end

   initial begin : stimulus
      stim_t idle;
      stim_t s;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
      bus.ex_rd = '0; bus.ex_mem_read = 1'b0; bus.ex_br_taken = 1'b0;
      bus.ex_mc_start = 1'b0; bus.mem_stall = 1'b0;

      reset_cycles(2, "reset");
      drive(idle, "idle");
      drive(mk(1, 5, 0, 1, 5, 1, 0, 0, 0), "lu_rs2");
      drive(idle, "lu_after");
      drive(mk(5, 2, 1, 0, 5, 1, 0, 0, 0), "lu_rs1");
      drive(mk(0, 0, 1, 1, 0, 1, 0, 0, 0), "lu_rd0");
      drive(mk(1, 5, 0, 0, 5, 1, 0, 0, 0), "lu_nouse");
      drive(mk(5, 5, 1, 1, 5, 0, 0, 0, 0), "lu_noload");
      drive(mk(1, 5, 0, 1, 5, 1, 1, 0, 0), "br_over_lu");

      reset_cycles(1, "reset_mc");
      for (int i = 0; i < MC_CYCLES + 1; i++) drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), "mc_held");
      drive(idle, "mc_done");

      drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), "mcs_start");
      drive(idle, "mcs_bubble");
      for (int i = 0; i < 3; i++) drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "mcs_memstall");
      drive(idle, "mcs_release");
      drive(idle, "mcs_after");

      drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), "rst_mc_start");
      drive(idle, "rst_mc_bubble");
      reset_cycles(1, "rst_mid_mc");
      drive(idle, "rst_mc_after");

      for (int i = 0; i < int'(SAT) + 6; i++) drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "sat");
      drive(idle, "sat_hold");

      reset_cycles(1, "reset_rnd");
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            reset_cycles(1, "rnd_rst");
         end else begin
            s.rs1 = REG_W'($urandom_range(0, 3));
            s.rs2 = REG_W'($urandom_range(0, 3));
            s.u1  = $urandom_range(0, 1) == 1;
            s.u2  = $urandom_range(0, 1) == 1;
            s.rd  = REG_W'($urandom_range(0, 3));
            s.mr  = $urandom_range(0, 1) == 1;
            s.br  = $urandom_range(0, 7) == 0;
            s.mc  = !s.br && ($urandom_range(0, 11) == 0);
            s.ms  = $urandom_range(0, 7) == 0;
            drive(s, "rnd");
         end
      end

      repeat (4) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
